// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//
// Shares the single data-memory port between the pipeline MEM stage (m0) and
// the debug/preload loader (m1). Ties are broken round-robin. One access runs
// at a time through a fixed IDLE -> ACCESS -> DONE sequence, which gives
// three cycles per access. Read data comes back registered together with a
// one-cycle acknowledge.
//
// Optional feature macro: DMARB_RANGE_CHECK_EN
//   When it is defined, the address is checked against [BASE, BASE+SIZE-1]
//   at grant. An out-of-range access never writes memory. It returns zero
//   data and signals mXErr together with its ack.
//
// Ports
//   clock, resetN          rising-edge clock, synchronous active-low reset
//   mXReq                  request, held by the requester until mXAck
//   mXWe/mXAddr/mXWdata    access descriptor, sampled at grant
//   mXAck                  one-cycle completion pulse
//   mXRdata                read data, non-zero only while mXAck is high
//   mXErr                  out-of-range flag with ack (range-check build only)
//   memWrite/memAddress/memData   drive the memory port
//   memOut                 combinational memory read data
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int BASE   = 1024,
    parameter int SIZE   = 256
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              m0Req,
    input  logic              m0We,
    input  logic [ADDR_W-1:0] m0Addr,
    input  logic [DATA_W-1:0] m0Wdata,
    output logic              m0Ack,
    output logic [DATA_W-1:0] m0Rdata,
    input  logic              m1Req,
    input  logic              m1We,
    input  logic [ADDR_W-1:0] m1Addr,
    input  logic [DATA_W-1:0] m1Wdata,
    output logic              m1Ack,
    output logic [DATA_W-1:0] m1Rdata,
`ifdef DMARB_RANGE_CHECK_EN
    output logic              m0Err,
    output logic              m1Err,
`endif
    output logic              memWrite,
    output logic [ADDR_W-1:0] memAddress,
    output logic [DATA_W-1:0] memData,
    input  logic [DATA_W-1:0] memOut
);

`ifdef DMARB_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE + SIZE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic                last_grant_reg, last_grant_next;  // id of the most recent winner
    logic                id_reg, id_next;
    logic                we_reg, we_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [DATA_W-1:0]   resp_reg, resp_next;
    logic                err_reg, err_next;

    // Requester inputs gathered into arrays so that the winner can be indexed
    logic [1:0]          req_vec;
    logic [1:0]          we_vec;
    logic [ADDR_W-1:0]   addr_vec  [2];
    logic [DATA_W-1:0]   wdata_vec [2];
    logic [1:0]          ack_vec;
    logic [DATA_W-1:0]   rdata_vec [2];

    logic                grant_valid;
    logic                grant_id;
    logic                mem_write;

    assign req_vec      = {m1Req, m0Req};
    assign we_vec       = {m1We, m0We};
    assign addr_vec[0]  = m0Addr;
    assign addr_vec[1]  = m1Addr;
    assign wdata_vec[0] = m0Wdata;
    assign wdata_vec[1] = m1Wdata;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >= FIRST_ADDR) && (a <= LAST_ADDR);
    endfunction

    // A lone requester wins. On a tie, the requester that was not served
    // last wins. The reset value of last_grant_reg is 1, so m0 wins the
    // first tie.
    always_comb begin
        grant_valid = |req_vec;
        if (&req_vec) begin
            grant_id = ~last_grant_reg;
        end else begin
            grant_id = req_vec[1];
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        id_next         = id_reg;
        we_next         = we_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        resp_next       = resp_reg;
        err_next        = err_reg;
        mem_write       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    state_next      = ACCESS;
                    last_grant_next = grant_id;
                    id_next         = grant_id;
                    we_next         = we_vec[grant_id];
                    addr_next       = addr_vec[grant_id];
                    wdata_next      = wdata_vec[grant_id];
                    err_next        = RANGE_EN & ~in_range(addr_vec[grant_id]);
                end
            end
            ACCESS: begin
                // Rejected accesses never reach memory and return zero data
                mem_write  = we_reg & ~err_reg;
                resp_next  = (we_reg | err_reg) ? '0 : memOut;
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            id_reg         <= 1'b0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            resp_reg       <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            id_reg         <= id_next;
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            resp_reg       <= resp_next;
            err_reg        <= err_next;
        end
    end

    // memWrite is decoded from the current state. A write that is in ACCESS
    // when reset is sampled therefore still commits on that edge.
    assign memWrite   = mem_write;
    assign memAddress = addr_reg;
    assign memData    = wdata_reg;

    // Ack and rdata are decoded from registered state. The ack of a DONE
    // cycle stays visible even when reset is sampled during that cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            assign ack_vec[gi]   = (state_reg == DONE) && (id_reg == 1'(gi));
            assign rdata_vec[gi] = ack_vec[gi] ? resp_reg : '0;
        end
    endgenerate

    assign m0Ack   = ack_vec[0];
    assign m1Ack   = ack_vec[1];
    assign m0Rdata = rdata_vec[0];
    assign m1Rdata = rdata_vec[1];

`ifdef DMARB_RANGE_CHECK_EN
    assign m0Err = ack_vec[0] & err_reg;
    assign m1Err = ack_vec[1] & err_reg;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
//
// Directed bench for data_mem_arbiter. It provides a behavioural model of the
// word-addressed data memory (window 1024..1279). That model writes on the
// rising edge and reads combinationally. Outputs are sampled 1 time unit
// after each rising edge.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

    logic        clock = 1'b0;
    logic        resetN;
    logic        m0Req, m0We, m1Req, m1We;
    logic [10:0] m0Addr, m1Addr;
    logic [31:0] m0Wdata, m1Wdata;
    logic        m0Ack, m1Ack;
    logic [31:0] m0Rdata, m1Rdata;
`ifdef DMARB_RANGE_CHECK_EN
    logic        m0Err, m1Err;
`endif
    logic        memWrite;
    logic [10:0] memAddress;
    logic [31:0] memData;
    logic [31:0] memOut;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    data_mem_arbiter dut (
        .clock      (clock),
        .resetN     (resetN),
        .m0Req      (m0Req),
        .m0We       (m0We),
        .m0Addr     (m0Addr),
        .m0Wdata    (m0Wdata),
        .m0Ack      (m0Ack),
        .m0Rdata    (m0Rdata),
        .m1Req      (m1Req),
        .m1We       (m1We),
        .m1Addr     (m1Addr),
        .m1Wdata    (m1Wdata),
        .m1Ack      (m1Ack),
        .m1Rdata    (m1Rdata),
`ifdef DMARB_RANGE_CHECK_EN
        .m0Err      (m0Err),
        .m1Err      (m1Err),
`endif
        .memWrite   (memWrite),
        .memAddress (memAddress),
        .memData    (memData),
        .memOut     (memOut)
    );

    // ---------------- memory model ----------------
    logic [31:0] mem [0:255];
    logic        load_en = 1'b1;
    logic [10:0] mem_off;
    logic        mem_hit;

    assign mem_off = memAddress - 11'd1024;
    assign mem_hit = (memAddress >= 11'd1024) && (memAddress < 11'd1280);
    assign memOut  = mem_hit ? mem[mem_off[7:0]] : 32'd0;

    always @(posedge clock) begin
        if (load_en) begin
            mem[0] <= 32'd0;
            mem[1] <= 32'd7;
            mem[2] <= 32'd200;
            mem[3] <= 32'd9;
        end else if (memWrite && mem_hit) begin
            mem[mem_off[7:0]] <= memData;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        resetN  = 1'b0;
        m0Req   = 1'b0; m0We = 1'b0; m0Addr = '0; m0Wdata = '0;
        m1Req   = 1'b0; m1We = 1'b0; m1Addr = '0; m1Wdata = '0;

        tick();
        load_en = 1'b0;
        tick();
        chk("rst_m0ack", m0Ack, 0);
        chk("rst_m1ack", m1Ack, 0);
        chk("rst_m0rdata", m0Rdata, 0);
        chk("rst_m1rdata", m1Rdata, 0);
        chk("rst_memwrite", memWrite, 0);
        chk("rst_memaddr", memAddress, 0);
        chk("rst_memdata", memData, 0);
        resetN = 1'b1;
        tick();

        // m0 write 200 to 1024
        m0Req = 1'b1; m0We = 1'b1; m0Addr = 11'd1024; m0Wdata = 32'd200;
        chk("w_idle_memwrite", memWrite, 0);
        tick();
        $display("step m0 write 1024 <= 200: ACCESS");
        chk("w_acc_memwrite", memWrite, 1);
        chk("w_acc_memaddr", memAddress, 1024);
        chk("w_acc_memdata", memData, 200);
        chk("w_acc_m0ack", m0Ack, 0);
        tick();
        chk("w_done_m0ack", m0Ack, 1);
        chk("w_done_m0rdata", m0Rdata, 0);
        chk("w_done_m1ack", m1Ack, 0);
        chk("w_done_memwrite", memWrite, 0);
        m0Req = 1'b0;                       // drop in DONE, m1 idle
        tick();
        chk("w_mem_committed", mem[0], 200);
        chk("idle_m0ack", m0Ack, 0);
        chk("idle_memwrite", memWrite, 0);
        chk("idle_memaddr_hold", memAddress, 1024);
        tick();
        chk("idle2_m0ack", m0Ack, 0);
        chk("idle2_memwrite", memWrite, 0);
        chk("idle2_memdata_hold", memData, 200);

        // m0 read back 1024
        m0Req = 1'b1; m0We = 1'b0; m0Addr = 11'd1024;
        tick();
        chk("r_acc_memwrite", memWrite, 0);
        tick();
        $display("step m0 read 1024: ack=%0d data=%0d", m0Ack, m0Rdata);
        chk("r_done_m0ack", m0Ack, 1);
        chk("r_done_m0rdata", m0Rdata, 200);
        m0Req = 1'b0;
        tick();

        // m1 read 1027 (preloaded 9)
        m1Req = 1'b1; m1We = 1'b0; m1Addr = 11'd1027;
        tick();
        chk("m1r_acc_memaddr", memAddress, 1027);
        tick();
        $display("step m1 read 1027: ack=%0d data=%0d", m1Ack, m1Rdata);
        chk("m1r_done_m1ack", m1Ack, 1);
        chk("m1r_done_m1rdata", m1Rdata, 9);
        chk("m1r_done_m0ack", m0Ack, 0);
        chk("m1r_done_m0rdata", m0Rdata, 0);
        m1Req = 1'b0;
        tick();

        // Reset then continuous tie: m1 was served last, so m0 must win first
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        tick();
        m0Req = 1'b1; m0We = 1'b0; m0Addr = 11'd1025;
        m1Req = 1'b1; m1We = 1'b0; m1Addr = 11'd1026;
        for (int k = 1; k <= 11; k++) begin
            tick();
            $display("step rr cycle %0d: m0Ack=%0d m1Ack=%0d", k, m0Ack, m1Ack);
            chk("rr_m0ack", m0Ack, (k == 2 || k == 8) ? 1 : 0);
            chk("rr_m1ack", m1Ack, (k == 5 || k == 11) ? 1 : 0);
            if (k == 2 || k == 8) chk("rr_m0rdata", m0Rdata, 7);
            if (k == 5 || k == 11) chk("rr_m1rdata", m1Rdata, 200);
        end
        m0Req = 1'b0; m1Req = 1'b0;
        tick();

        // Reset sampled during ACCESS of an m1 write
        m1Req = 1'b1; m1We = 1'b1; m1Addr = 11'd1025; m1Wdata = 32'd5;
        tick();
        chk("rsta_acc_memwrite", memWrite, 1);
        resetN = 1'b0;
        tick();
        $display("step reset in ACCESS: mem[1025]=%0d m1Ack=%0d", mem[1], m1Ack);
        chk("rsta_mem_committed", mem[1], 5);
        chk("rsta_m1ack", m1Ack, 0);
        chk("rsta_m0ack", m0Ack, 0);
        chk("rsta_memwrite", memWrite, 0);
        chk("rsta_memaddr", memAddress, 0);
        chk("rsta_memdata", memData, 0);
        chk("rsta_m1rdata", m1Rdata, 0);
        m1Req = 1'b0;
        tick();
        chk("rsta_m1ack_late", m1Ack, 0);
        resetN = 1'b1;
        tick();

        // Post-reset tie goes to m0; then reset during DONE
        m0Req = 1'b1; m0We = 1'b0; m0Addr = 11'd1025;
        m1Req = 1'b1; m1We = 1'b0; m1Addr = 11'd1026;
        tick();
        chk("tie_acc_memaddr", memAddress, 1025);
        tick();
        $display("step post-reset tie: m0Ack=%0d m0Rdata=%0d", m0Ack, m0Rdata);
        chk("tie_done_m0ack", m0Ack, 1);
        chk("tie_done_m0rdata", m0Rdata, 5);
        chk("tie_done_m1ack", m1Ack, 0);
        resetN = 1'b0;
        #1;
        chk("rstd_ack_visible", m0Ack, 1);
        tick();
        chk("rstd_m0ack", m0Ack, 0);
        chk("rstd_m1ack", m1Ack, 0);
        chk("rstd_memaddr", memAddress, 0);
        chk("rstd_m0rdata", m0Rdata, 0);
        m0Req = 1'b0; m1Req = 1'b0;
        resetN = 1'b1;
        tick();

`ifdef DMARB_RANGE_CHECK_EN
        // Out-of-range write is rejected, then an in-range read succeeds
        m0Req = 1'b1; m0We = 1'b1; m0Addr = 11'd1300; m0Wdata = 32'd77;
        tick();
        chk("oor_acc_memwrite", memWrite, 0);
        tick();
        $display("step m0 write 1300: ack=%0d err=%0d", m0Ack, m0Err);
        chk("oor_done_m0ack", m0Ack, 1);
        chk("oor_done_m0err", m0Err, 1);
        chk("oor_done_m0rdata", m0Rdata, 0);
        chk("oor_done_m1err", m1Err, 0);
        m0We = 1'b0; m0Addr = 11'd1024;
        tick();
        tick();
        tick();
        $display("step m0 read 1024 after error: ack=%0d err=%0d", m0Ack, m0Err);
        chk("inr_done_m0ack", m0Ack, 1);
        chk("inr_done_m0err", m0Err, 0);
        chk("inr_done_m0rdata", m0Rdata, 200);
        m0Req = 1'b0;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
